// File: rtl/branch_pkg.sv
// Shared types and encodings for the conditional-branch sequencer.
// Used by branch_cond_eval and branch_sequencer.
package branch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TARGET  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_RESOLVE = 2'd3
    } state_e;

    localparam logic [5:0] OP_BLTZ = 6'd1;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLEZ = 6'd6;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_ZERO   = 2'b10;
    localparam logic [1:0] SRC_B_OFFSET = 2'b11;

    localparam logic [1:0] PC_SRC_DEFAULT = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT  = 2'b01;

    // Single-register branches compare regA against zero rather than regB.
    function automatic logic compares_zero(input logic [5:0] op);
        return (op == OP_BLTZ) || (op == OP_BLEZ) || (op == OP_BGTZ);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: maps opcode and ALU flags to a decision,
// and flags whether the opcode is a conditional branch at all.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       igual,
    input  logic       maior,
    input  logic       menor,
    output logic       cond,
    output logic       is_branch
);

    always_comb begin
        cond      = 1'b0;
        is_branch = 1'b1;
        case (opcode)
            OP_BEQ:  cond = igual;
            OP_BNE:  cond = ~igual;
            OP_BLEZ: cond = ~maior;
            OP_BGTZ: cond = maior;
            OP_BLTZ: cond = menor;
            default: is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multicycle conditional-branch controller driving the shared ALU and PC path.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             igual,
    input  logic             maior,
    input  logic             menor,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             illegal,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             aluout_wr,
    output logic             pc_write,
    output logic [1:0]       pc_source,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt,
`endif
    output state_e           dbg_state
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       taken_q, taken_d;
    logic       illegal_q, illegal_d;
    logic       busy_q, busy_d;
    logic [5:0] eval_op;
    logic       cond, is_branch;

    // In IDLE the live opcode is classified; afterwards the latched one.
    assign eval_op = (state_q == ST_IDLE) ? opcode : opcode_q;

    branch_cond_eval u_cond (
        .opcode    (eval_op),
        .igual     (igual),
        .maior     (maior),
        .menor     (menor),
        .cond      (cond),
        .is_branch (is_branch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 6'd0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        done      = 1'b0;
        illegal   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_IDLE;
        aluout_wr = 1'b0;
        pc_write  = 1'b0;
        pc_source = PC_SRC_DEFAULT;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opcode_d  = opcode;
                    taken_d   = 1'b0;
                    illegal_d = ~is_branch;
                    state_d   = is_branch ? ST_TARGET : ST_RESOLVE;
                end
            end
            ST_TARGET: begin
                alu_src_b = SRC_B_OFFSET;
                alu_op    = ALU_ADD;
                aluout_wr = 1'b1;
                state_d   = ST_COMPARE;
            end
            ST_COMPARE: begin
                alu_src_a = 1'b1;
                alu_src_b = compares_zero(opcode_q) ? SRC_B_ZERO : SRC_B_REG;
                alu_op    = ALU_SUB;
                taken_d   = cond;
                state_d   = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                done      = 1'b1;
                illegal   = illegal_q;
                pc_source = PC_SRC_ALUOUT;
                pc_write  = taken_q & ~illegal_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign busy      = busy_q;
    assign taken     = taken_q;
    assign dbg_state = state_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, not_taken_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if (state_q == ST_RESOLVE && !illegal_q) begin
            if (taken_q && !(&taken_cnt_q))
                taken_cnt_q <= taken_cnt_q + 1'b1;
            if (!taken_q && !(&not_taken_cnt_q))
                not_taken_cnt_q <= not_taken_cnt_q + 1'b1;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule
